param_reg_file: RTL and testbench

PARAM_REG_FILE -- requirements
Module: param_reg_file

---
 rtl/param_reg_file.sv | 137 +++++++++++++
 tb/tb_param_reg_file.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_reg_file.sv
// ---------------------------------------------------------------------------
// param_reg_file
//   Parameterised register file with one write port and two independent,
//   registered read ports. It tracks which registers were written since the
//   last reset/clear and keeps a sticky flag for any out-of-range access.
//
// Optional feature (macro PARAM_REG_FILE_BYPASS_EN):
//   defined   : a read that coincides with an in-range write to the same
//               address returns the new wdata (write-to-read bypass).
//   undefined : that read returns the pre-write register contents.
//
// Parameters
//   WIDTH : data width in bits (>= 1)
//   DEPTH : number of registers (2..256)
//   AW    : address width, 2**AW >= DEPTH
//
// Ports
//   clk              : clock, all state updates on the rising edge
//   reset            : asynchronous, active-high reset
//   clear            : synchronous clear of registers, written and err
//   we/waddr/wdata   : write request
//   re0/raddr0       : read request, port 0
//   re1/raddr1       : read request, port 1
//   rdata0/rdata1    : registered read data
//   rvalid0/rvalid1  : read-data-valid pulses
//   written          : per-register "written since reset/clear" flags
//   err              : sticky out-of-range access flag
//
// Handshake: the read ports have no ready. A request (rek=1) is always
// accepted at the rising edge; the data appears on rdatak one cycle later
// with rvalidk=1 for exactly that one cycle. The consumer must capture
// rdatak while rvalidk is high; rdatak holds its value between reads.
// ---------------------------------------------------------------------------
module param_reg_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re0,
  input  logic [AW-1:0]    raddr0,
  input  logic             re1,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [DEPTH-1:0] written,
  output logic             err
);

  // One extra bit so DEPTH = 2**AW is representable in the range compare.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];

  logic             waddr_ok;
  logic             raddr0_ok;
  logic             raddr1_ok;
  logic             wr_en;
  logic             oor_access;
  logic [WIDTH-1:0] rd0_val;
  logic [WIDTH-1:0] rd1_val;

  assign waddr_ok   = ({1'b0, waddr}  < DEPTH_W);
  assign raddr0_ok  = ({1'b0, raddr0} < DEPTH_W);
  assign raddr1_ok  = ({1'b0, raddr1} < DEPTH_W);
  assign wr_en      = we && waddr_ok && !clear;
  assign oor_access = (we && !waddr_ok) || (re0 && !raddr0_ok) ||
                      (re1 && !raddr1_ok);

  // Read muxes. An address that matches no register leaves the value at 0,
  // which is exactly the out-of-range read result.
  always_comb begin
    rd0_val = '0;
    rd1_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr0 == AW'(i)) rd0_val = regs[i];
      if (raddr1 == AW'(i)) rd1_val = regs[i];
    end
`ifdef PARAM_REG_FILE_BYPASS_EN
    // wr_en already implies an in-range address and no clear.
    if (wr_en && (waddr == raddr0)) rd0_val = wdata;
    if (wr_en && (waddr == raddr1)) rd1_val = wdata;
`endif
  end

  // Register array and written flags; clear wins over a same-cycle write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      written <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      written <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == AW'(i)) begin
          regs[i]    <= wdata;
          written[i] <= 1'b1;
        end
      end
    end
  end

  // Sticky error flag; a clear cycle always leaves it at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (clear) begin
      err <= 1'b0;
    end else if (oor_access) begin
      err <= 1'b1;
    end
  end

  // Registered read ports. A read in a clear cycle returns 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= re0;
      rvalid1 <= re1;
      if (re0) rdata0 <= clear ? '0 : rd0_val;
      if (re1) rdata1 <= clear ? '0 : rd1_val;
    end
  end

endmodule

// File: tb/tb_param_reg_file.sv
// ---------------------------------------------------------------------------
// tb_param_reg_file
//   Drives two instances (DEPTH=4 and DEPTH=3, both AW=2) from one shared
//   stimulus and checks both against an abstract model of the register file.
//   Directed table vectors cover the basic write/read/bypass/clear flow,
//   hand sequences cover out-of-range access and mid-stream reset, and a
//   randomized phase exercises everything against the model.
// ---------------------------------------------------------------------------
module tb_param_reg_file;

`ifdef PARAM_REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic       clear, we, re0, re1;
  logic [1:0] waddr, raddr0, raddr1;
  logic [7:0] wdata;

  logic [7:0] a_rd0, a_rd1, b_rd0, b_rd1;
  logic       a_rv0, a_rv1, b_rv0, b_rv1, a_err, b_err;
  logic [3:0] a_wr;
  logic [2:0] b_wr;

  param_reg_file #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .waddr(waddr),
    .wdata(wdata), .re0(re0), .raddr0(raddr0), .re1(re1), .raddr1(raddr1),
    .rdata0(a_rd0), .rdata1(a_rd1), .rvalid0(a_rv0), .rvalid1(a_rv1),
    .written(a_wr), .err(a_err)
  );

  param_reg_file #(.WIDTH(8), .DEPTH(3), .AW(2)) dut3 (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .waddr(waddr),
    .wdata(wdata), .re0(re0), .raddr0(raddr0), .re1(re1), .raddr1(raddr1),
    .rdata0(b_rd0), .rdata1(b_rd1), .rvalid0(b_rv0), .rvalid1(b_rv1),
    .written(b_wr), .err(b_err)
  );

  // ---------------- scoreboard counters ----------------
  int tests;
  int fails;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0 models the DEPTH=4 instance, index 1 the DEPTH=3 instance.
  int m_reg [2][4];
  int m_written [2];
  int m_err [2];
  int m_rd0 [2];
  int m_rd1 [2];
  int m_rv0 [2];
  int m_rv1 [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m_reg[k][i] = 0;
      m_written[k] = 0; m_err[k] = 0;
      m_rd0[k] = 0; m_rd1[k] = 0; m_rv0[k] = 0; m_rv1[k] = 0;
    end
  endtask

  function automatic int read_val(input int k, input int d, input int ra);
    if (clear) return 0;
    if (ra >= d) return 0;
    if (BYP && we && int'(waddr) == ra) return int'(wdata);
    return m_reg[k][ra];
  endfunction

  // One rising edge worth of behaviour for instance k with depth d.
  task automatic model_step(input int k, input int d);
    m_rv0[k] = int'(re0);
    m_rv1[k] = int'(re1);
    if (re0) m_rd0[k] = read_val(k, d, int'(raddr0));
    if (re1) m_rd1[k] = read_val(k, d, int'(raddr1));
    if (clear) begin
      for (int i = 0; i < 4; i++) m_reg[k][i] = 0;
      m_written[k] = 0;
      m_err[k] = 0;
    end else begin
      if ((we && int'(waddr) >= d) || (re0 && int'(raddr0) >= d) ||
          (re1 && int'(raddr1) >= d))
        m_err[k] = 1;
      if (we && int'(waddr) < d) begin
        m_reg[k][waddr] = int'(wdata);
        m_written[k] = m_written[k] | (1 << waddr);
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " d4 rdata0"},  32'(a_rd0), 32'(m_rd0[0]));
    check({tag, " d4 rdata1"},  32'(a_rd1), 32'(m_rd1[0]));
    check({tag, " d4 rvalid0"}, 32'(a_rv0), 32'(m_rv0[0]));
    check({tag, " d4 rvalid1"}, 32'(a_rv1), 32'(m_rv1[0]));
    check({tag, " d4 written"}, 32'(a_wr),  32'(m_written[0]));
    check({tag, " d4 err"},     32'(a_err), 32'(m_err[0]));
    check({tag, " d3 rdata0"},  32'(b_rd0), 32'(m_rd0[1]));
    check({tag, " d3 rdata1"},  32'(b_rd1), 32'(m_rd1[1]));
    check({tag, " d3 rvalid0"}, 32'(b_rv0), 32'(m_rv0[1]));
    check({tag, " d3 rvalid1"}, 32'(b_rv1), 32'(m_rv1[1]));
    check({tag, " d3 written"}, 32'(b_wr),  32'(m_written[1]));
    check({tag, " d3 err"},     32'(b_err), 32'(m_err[1]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    clear = 0; we = 0; re0 = 0; re1 = 0;
    waddr = 0; raddr0 = 0; raddr1 = 0; wdata = 0;
  endtask

  // Inputs are already set by the caller; take one edge, step the model
  // with the values seen at that edge, then check 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step(0, 4);
    model_step(1, 3);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  task automatic check_zero_d4(input string tag);
    check({tag, " rdata0"},  32'(a_rd0), 32'h0);
    check({tag, " rdata1"},  32'(a_rd1), 32'h0);
    check({tag, " rvalid0"}, 32'(a_rv0), 32'h0);
    check({tag, " rvalid1"}, 32'(a_rv1), 32'h0);
    check({tag, " written"}, 32'(a_wr),  32'h0);
    check({tag, " err"},     32'(a_err), 32'h0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic       re0;
    logic [1:0] raddr0;
    logic       re1;
    logic [1:0] raddr1;
    logic       clear;
    logic [7:0] e_rd0;
    logic       e_rv0;
    logic [7:0] e_rd1;
    logic       e_rv1;
    logic [3:0] e_wr;
    logic       e_err;
  } vec_t;

  function automatic vec_t mk(
    input logic w, input logic [1:0] wa, input logic [7:0] wd,
    input logic r0, input logic [1:0] ra0, input logic r1,
    input logic [1:0] ra1, input logic cl,
    input logic [7:0] d0, input logic v0, input logic [7:0] d1,
    input logic v1, input logic [3:0] wr, input logic e);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.re0 = r0; v.raddr0 = ra0;
    v.re1 = r1; v.raddr1 = ra1; v.clear = cl; v.e_rd0 = d0; v.e_rv0 = v0;
    v.e_rd1 = d1; v.e_rv1 = v1; v.e_wr = wr; v.e_err = e;
    return v;
  endfunction

  vec_t vecs [11];

  initial begin
    tests = 0;
    fails = 0;
    idle_inputs();
    model_reset();
    reset = 1;

    //              we wa  wdata  re0 ra0 re1 ra1 clr  rd0   v0 rd1          v1 wr       err
    vecs[0]  = mk(1, 2'd1, 8'hA5, 0, 2'd0, 0, 2'd0, 0, 8'h00, 0, 8'h00,      0, 4'b0010, 0);
    vecs[1]  = mk(0, 2'd0, 8'h00, 1, 2'd1, 0, 2'd0, 0, 8'hA5, 1, 8'h00,      0, 4'b0010, 0);
    vecs[2]  = mk(0, 2'd0, 8'h00, 0, 2'd0, 0, 2'd0, 0, 8'hA5, 0, 8'h00,      0, 4'b0010, 0);
    vecs[3]  = mk(1, 2'd2, 8'h3C, 0, 2'd0, 1, 2'd2, 0, 8'hA5, 0,
                  BYP ? 8'h3C : 8'h00, 1, 4'b0110, 0);
    vecs[4]  = mk(0, 2'd0, 8'h00, 0, 2'd0, 1, 2'd2, 0, 8'hA5, 0, 8'h3C,      1, 4'b0110, 0);
    vecs[5]  = mk(1, 2'd0, 8'h11, 0, 2'd0, 0, 2'd0, 0, 8'hA5, 0, 8'h3C,      0, 4'b0111, 0);
    vecs[6]  = mk(1, 2'd3, 8'h22, 0, 2'd0, 0, 2'd0, 0, 8'hA5, 0, 8'h3C,      0, 4'b1111, 0);
    vecs[7]  = mk(1, 2'd0, 8'h77, 1, 2'd0, 0, 2'd0, 1, 8'h00, 1, 8'h3C,      0, 4'b0000, 0);
    vecs[8]  = mk(0, 2'd0, 8'h00, 1, 2'd0, 1, 2'd0, 0, 8'h00, 1, 8'h00,      1, 4'b0000, 0);
    vecs[9]  = mk(1, 2'd0, 8'h5A, 0, 2'd0, 0, 2'd0, 0, 8'h00, 0, 8'h00,      0, 4'b0001, 0);
    vecs[10] = mk(0, 2'd0, 8'h00, 1, 2'd0, 1, 2'd0, 0, 8'h5A, 1, 8'h5A,      1, 4'b0001, 0);

    // Reset state, checked while reset is still asserted.
    #2;
    check_zero_d4("reset state d4");
    check("reset state d3 written", 32'(b_wr), 32'h0);
    check("reset state d3 err", 32'(b_err), 32'h0);
    repeat (2) @(negedge clk);
    reset = 0;

    // Table-driven directed flow on the DEPTH=4 instance.
    for (int i = 0; i < 11; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      re0 = vecs[i].re0; raddr0 = vecs[i].raddr0;
      re1 = vecs[i].re1; raddr1 = vecs[i].raddr1; clear = vecs[i].clear;
      cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d rdata0", i),  32'(a_rd0), 32'(vecs[i].e_rd0));
      check($sformatf("vec%0d rvalid0", i), 32'(a_rv0), 32'(vecs[i].e_rv0));
      check($sformatf("vec%0d rdata1", i),  32'(a_rd1), 32'(vecs[i].e_rd1));
      check($sformatf("vec%0d rvalid1", i), 32'(a_rv1), 32'(vecs[i].e_rv1));
      check($sformatf("vec%0d written", i), 32'(a_wr),  32'(vecs[i].e_wr));
      check($sformatf("vec%0d err", i),     32'(a_err), 32'(vecs[i].e_err));
    end

    // Mid-stream reset: both ports reading 0x5A, then reset between edges.
    idle_inputs();
    re0 = 1; re1 = 1;
    cycle("stream");
    check("stream rdata0", 32'(a_rd0), 32'h5A);
    check("stream rdata1", 32'(a_rd1), 32'h5A);
    check("stream rvalid0", 32'(a_rv0), 32'h1);
    #2;
    reset = 1;
    #1;
    check_zero_d4("async reset");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero_d4("reset held");
    end
    @(negedge clk);
    reset = 0;
    model_reset();
    re0 = 0; re1 = 0;
    cycle("post reset idle");
    check("post reset rvalid0", 32'(a_rv0), 32'h0);
    check("post reset rvalid1", 32'(a_rv1), 32'h0);
    re0 = 1;
    cycle("post reset read");
    check("post reset read rvalid0", 32'(a_rv0), 32'h1);
    check("post reset read rdata0", 32'(a_rd0), 32'h0);

    // Out-of-range write and read on the DEPTH=3 instance.
    do_reset();
    we = 1; waddr = 2'd0; wdata = 8'h12;
    cycle("d3 prime");
    waddr = 2'd3; wdata = 8'hFF;
    cycle("d3 oor write");
    check("d3 oor write err", 32'(b_err), 32'h1);
    check("d3 oor write written", 32'(b_wr), 32'b001);
    we = 0; re0 = 1; raddr0 = 2'd3;
    cycle("d3 oor read");
    check("d3 oor read rdata0", 32'(b_rd0), 32'h0);
    check("d3 oor read rvalid0", 32'(b_rv0), 32'h1);
    check("d3 oor read err", 32'(b_err), 32'h1);
    for (int a = 0; a < 3; a++) begin
      raddr0 = 2'(a);
      cycle("d3 readback");
      check($sformatf("d3 readback addr%0d", a), 32'(b_rd0),
            (a == 0) ? 32'h12 : 32'h0);
    end
    re0 = 0; clear = 1; we = 1; waddr = 2'd3;
    cycle("d3 clear with oor");
    check("d3 clear with oor err", 32'(b_err), 32'h0);
    clear = 0; we = 0;

    // Randomized phase, both instances against the model.
    for (int n = 0; n < 400; n++) begin
      we     = 1'($urandom_range(0, 1));
      waddr  = 2'($urandom_range(0, 3));
      wdata  = 8'($urandom_range(0, 255));
      re0    = 1'($urandom_range(0, 1));
      raddr0 = 2'($urandom_range(0, 3));
      re1    = 1'($urandom_range(0, 1));
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 2'($urandom_range(0, 3));
      clear  = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
